// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared types for the iBus/dBus arbiter: requester identity and the
// byte-mask value driven for instruction fetches.
package arb_pkg;

    typedef enum logic {
        REQ_IBUS = 1'b0,
        REQ_DBUS = 1'b1
    } req_id_e;

    localparam logic [3:0] MASK_NONE = 4'h0;

endpackage : arb_pkg

// File: rtl/ibus_dbus_arbiter_tag_fifo.sv
// One-bit-wide tag FIFO recording which requester owns each outstanding
// read, so in-order memory responses can be routed back to the right bus.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstf,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags come from the registered count only.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == {CNT_W{1'b0}});
        head      = mem_q[rd_ptr_q];
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every outstanding tag.
    always_ff @(posedge clk) begin
        if (!rstf) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : tag_fifo

// File: rtl/ibus_dbus_arbiter.sv
// Round-robin arbiter sharing one memory command/response port between the
// instruction fetch bus and the data bus. Command and response paths are
// combinational; a stalled command locks the grant until its handshake.
module ibus_dbus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic              iBus_cmd_valid,
    output logic              iBus_cmd_ready,
    input  logic [ADDR_W-1:0] iBus_cmd_payload_pc,
    output logic              iBus_rsp_ready,
    output logic [DATA_W-1:0] iBus_rsp_instr,
    input  logic              dBus_cmd_valid,
    output logic              dBus_cmd_ready,
    input  logic [ADDR_W-1:0] dBus_cmd_payload_addr,
    input  logic [DATA_W-1:0] dBus_cmd_payload_data,
    input  logic [3:0]        dBus_cmd_payload_size,
    input  logic              dBus_cmd_payload_wr,
    output logic              dBus_rsp_valid,
    output logic [DATA_W-1:0] dBus_rsp_data,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic              m_cmd_we,
    output logic [ADDR_W-1:0] m_cmd_addr,
    output logic [DATA_W-1:0] m_cmd_data,
    output logic [3:0]        m_cmd_mask,
    input  logic              m_rsp_valid,
    input  logic [DATA_W-1:0] m_rsp_data,
    output logic              protocol_err
);

    req_id_e last_grant_q, last_grant_d;
    req_id_e owner_q, owner_d;
    logic    lock_q, lock_d;
    logic    protocol_err_q, protocol_err_d;

    req_id_e grant_s;
    logic    i_elig_s;
    logic    d_elig_s;
    logic    grant_elig_s;
    logic    handshake_s;
    logic    fifo_full_s;
    logic    fifo_empty_s;
    logic    fifo_head_s;
    logic    fifo_push_s;
    logic    fifo_pop_s;

    tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .rstf     (rstf),
        .push     (fifo_push_s),
        .push_tag (grant_s == REQ_DBUS),
        .pop      (fifo_pop_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .head     (fifo_head_s)
    );

    // Eligibility and grant selection: lock wins, then single requester,
    // then the requester that did not win the last handshake.
    always_comb begin
        i_elig_s = iBus_cmd_valid && !fifo_full_s;
        d_elig_s = dBus_cmd_valid && (dBus_cmd_payload_wr || !fifo_full_s);
        grant_s  = REQ_IBUS;
        if (lock_q) begin
            grant_s = owner_q;
        end else if (i_elig_s && d_elig_s) begin
            grant_s = (last_grant_q == REQ_DBUS) ? REQ_IBUS : REQ_DBUS;
        end else if (d_elig_s) begin
            grant_s = REQ_DBUS;
        end else begin
            grant_s = REQ_IBUS;
        end
        grant_elig_s = (grant_s == REQ_DBUS) ? d_elig_s : i_elig_s;
    end

    // Command mux toward memory and per-requester ready.
    always_comb begin
        m_cmd_valid    = rstf && grant_elig_s;
        handshake_s    = m_cmd_valid && m_cmd_ready;
        iBus_cmd_ready = 1'b0;
        dBus_cmd_ready = 1'b0;
        case (grant_s)
            REQ_DBUS: begin
                m_cmd_we       = dBus_cmd_payload_wr;
                m_cmd_addr     = dBus_cmd_payload_addr;
                m_cmd_data     = dBus_cmd_payload_data;
                m_cmd_mask     = dBus_cmd_payload_size;
                dBus_cmd_ready = handshake_s;
            end
            default: begin
                m_cmd_we       = 1'b0;
                m_cmd_addr     = iBus_cmd_payload_pc;
                m_cmd_data     = {DATA_W{1'b0}};
                m_cmd_mask     = MASK_NONE;
                iBus_cmd_ready = handshake_s;
            end
        endcase
        fifo_push_s = handshake_s && !m_cmd_we;
    end

    // Response routing by the FIFO head tag; empty-FIFO responses are dropped.
    always_comb begin
        fifo_pop_s     = rstf && m_rsp_valid && !fifo_empty_s;
        iBus_rsp_ready = fifo_pop_s && (fifo_head_s == 1'b0);
        dBus_rsp_valid = fifo_pop_s && (fifo_head_s == 1'b1);
        iBus_rsp_instr = m_rsp_data;
        dBus_rsp_data  = m_rsp_data;
        protocol_err   = protocol_err_q;
    end

    // Next state for lock, owner, round-robin pointer and sticky error.
    always_comb begin
        lock_d         = m_cmd_valid && !m_cmd_ready;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        protocol_err_d = protocol_err_q;
        if (lock_d) begin
            owner_d = grant_s;
        end else begin
            owner_d = owner_q;
        end
        if (handshake_s) begin
            last_grant_d = grant_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (m_rsp_valid && fifo_empty_s) begin
            protocol_err_d = 1'b1;
        end else begin
            protocol_err_d = protocol_err_q;
        end
    end

    // Arbiter state registers; after reset iBus wins the first tie.
    always_ff @(posedge clk) begin
        if (!rstf) begin
            lock_q         <= 1'b0;
            owner_q        <= REQ_IBUS;
            last_grant_q   <= REQ_DBUS;
            protocol_err_q <= 1'b0;
        end else begin
            lock_q         <= lock_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            protocol_err_q <= protocol_err_d;
        end
    end

endmodule : ibus_dbus_arbiter

// File: tb/tb_ibus_dbus_arbiter.sv
// Directed self-checking bench for ibus_dbus_arbiter.
module tb_ibus_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rstf;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready;
    logic [31:0] iBus_rsp_instr;
    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic [31:0] dBus_cmd_payload_addr;
    logic [31:0] dBus_cmd_payload_data;
    logic [3:0]  dBus_cmd_payload_size;
    logic        dBus_cmd_payload_wr;
    logic        dBus_rsp_valid;
    logic [31:0] dBus_rsp_data;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic        m_cmd_we;
    logic [31:0] m_cmd_addr;
    logic [31:0] m_cmd_data;
    logic [3:0]  m_cmd_mask;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;
    logic        protocol_err;

    int errors = 0;
    int checks = 0;

    ibus_dbus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_OUT (4)
    ) dut (
        .clk                   (clk),
        .rstf                  (rstf),
        .iBus_cmd_valid        (iBus_cmd_valid),
        .iBus_cmd_ready        (iBus_cmd_ready),
        .iBus_cmd_payload_pc   (iBus_cmd_payload_pc),
        .iBus_rsp_ready        (iBus_rsp_ready),
        .iBus_rsp_instr        (iBus_rsp_instr),
        .dBus_cmd_valid        (dBus_cmd_valid),
        .dBus_cmd_ready        (dBus_cmd_ready),
        .dBus_cmd_payload_addr (dBus_cmd_payload_addr),
        .dBus_cmd_payload_data (dBus_cmd_payload_data),
        .dBus_cmd_payload_size (dBus_cmd_payload_size),
        .dBus_cmd_payload_wr   (dBus_cmd_payload_wr),
        .dBus_rsp_valid        (dBus_rsp_valid),
        .dBus_rsp_data         (dBus_rsp_data),
        .m_cmd_valid           (m_cmd_valid),
        .m_cmd_ready           (m_cmd_ready),
        .m_cmd_we              (m_cmd_we),
        .m_cmd_addr            (m_cmd_addr),
        .m_cmd_data            (m_cmd_data),
        .m_cmd_mask            (m_cmd_mask),
        .m_rsp_valid           (m_rsp_valid),
        .m_rsp_data            (m_rsp_data),
        .protocol_err          (protocol_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstf                  = 1'b0;
        iBus_cmd_valid        = 1'b0;
        iBus_cmd_payload_pc   = 32'h0;
        dBus_cmd_valid        = 1'b0;
        dBus_cmd_payload_addr = 32'h0;
        dBus_cmd_payload_data = 32'h0;
        dBus_cmd_payload_size = 4'h0;
        dBus_cmd_payload_wr   = 1'b0;
        m_cmd_ready           = 1'b0;
        m_rsp_valid           = 1'b0;
        m_rsp_data            = 32'h0;
        tick();
        tick();

        // Reset: outputs gated even with requests present.
        iBus_cmd_valid = 1'b1;
        dBus_cmd_valid = 1'b1;
        m_cmd_ready    = 1'b1;
        #1;
        chk("rst_mvalid", m_cmd_valid, 0);
        chk("rst_iready", iBus_cmd_ready, 0);
        chk("rst_dready", dBus_cmd_ready, 0);
        chk("rst_perr", protocol_err, 0);

        // Test 1: alternating grants, 1-cycle memory latency.
        tick();
        rstf                  = 1'b1;
        iBus_cmd_payload_pc   = 32'h1000;
        dBus_cmd_payload_addr = 32'h2000;
        dBus_cmd_payload_size = 4'hF;
        dBus_cmd_payload_wr   = 1'b0;
        #1;
        chk("t1a_iready", iBus_cmd_ready, 1);
        chk("t1a_dready", dBus_cmd_ready, 0);
        chk("t1a_addr", m_cmd_addr, 32'h1000);
        chk("t1a_we", m_cmd_we, 0);
        chk("t1a_mask", m_cmd_mask, 4'h0);
        chk("t1a_data", m_cmd_data, 32'h0);
        tick();
        m_rsp_valid = 1'b1;
        m_rsp_data  = 32'hAAAA0001;
        #1;
        chk("t1b_dready", dBus_cmd_ready, 1);
        chk("t1b_iready", iBus_cmd_ready, 0);
        chk("t1b_addr", m_cmd_addr, 32'h2000);
        chk("t1b_mask", m_cmd_mask, 4'hF);
        chk("t1b_irsp", iBus_rsp_ready, 1);
        chk("t1b_instr", iBus_rsp_instr, 32'hAAAA0001);
        chk("t1b_drsp", dBus_rsp_valid, 0);
        tick();
        m_rsp_data = 32'hBBBB0002;
        #1;
        chk("t1c_iready", iBus_cmd_ready, 1);
        chk("t1c_drsp", dBus_rsp_valid, 1);
        chk("t1c_ddata", dBus_rsp_data, 32'hBBBB0002);
        chk("t1c_irsp", iBus_rsp_ready, 0);
        tick();
        m_rsp_data = 32'hCCCC0003;
        #1;
        chk("t1d_dready", dBus_cmd_ready, 1);
        chk("t1d_irsp", iBus_rsp_ready, 1);
        chk("t1d_instr", iBus_rsp_instr, 32'hCCCC0003);
        tick();
        iBus_cmd_valid = 1'b0;
        dBus_cmd_valid = 1'b0;
        m_rsp_data     = 32'hDDDD0004;
        #1;
        chk("t1e_drsp", dBus_rsp_valid, 1);
        chk("t1e_ddata", dBus_rsp_data, 32'hDDDD0004);
        chk("t1e_mvalid", m_cmd_valid, 0);

        // Test 2: stalled dBus write locks the grant.
        tick();
        m_rsp_valid           = 1'b0;
        m_cmd_ready           = 1'b0;
        dBus_cmd_valid        = 1'b1;
        dBus_cmd_payload_wr   = 1'b1;
        dBus_cmd_payload_addr = 32'h40;
        dBus_cmd_payload_data = 32'hDEADBEEF;
        dBus_cmd_payload_size = 4'hF;
        #1;
        chk("t2a_mvalid", m_cmd_valid, 1);
        chk("t2a_we", m_cmd_we, 1);
        chk("t2a_addr", m_cmd_addr, 32'h40);
        chk("t2a_data", m_cmd_data, 32'hDEADBEEF);
        chk("t2a_dready", dBus_cmd_ready, 0);
        tick();
        iBus_cmd_valid      = 1'b1;
        iBus_cmd_payload_pc = 32'h80;
        #1;
        chk("t2b_addr", m_cmd_addr, 32'h40);
        chk("t2b_data", m_cmd_data, 32'hDEADBEEF);
        chk("t2b_mask", m_cmd_mask, 4'hF);
        chk("t2b_iready", iBus_cmd_ready, 0);
        tick();
        #1;
        chk("t2c_addr", m_cmd_addr, 32'h40);
        chk("t2c_we", m_cmd_we, 1);
        tick();
        m_cmd_ready = 1'b1;
        #1;
        chk("t2d_dready", dBus_cmd_ready, 1);
        chk("t2d_iready", iBus_cmd_ready, 0);
        tick();
        dBus_cmd_valid = 1'b0;
        #1;
        chk("t2e_iready", iBus_cmd_ready, 1);
        chk("t2e_addr", m_cmd_addr, 32'h80);
        chk("t2e_we", m_cmd_we, 0);
        tick();
        iBus_cmd_valid = 1'b0;
        m_rsp_valid    = 1'b1;
        m_rsp_data     = 32'h55;
        #1;
        chk("t2f_irsp", iBus_rsp_ready, 1);
        chk("t2f_instr", iBus_rsp_instr, 32'h55);

        // Test 3: fill the tag FIFO with four fetches.
        tick();
        m_rsp_valid    = 1'b0;
        iBus_cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iBus_cmd_payload_pc = 32'h100 + 32'(4 * k);
            #1;
            chk("t3_fill_iready", iBus_cmd_ready, 1);
            chk("t3_fill_addr", m_cmd_addr, 32'h100 + 32'(4 * k));
            tick();
        end
        iBus_cmd_payload_pc   = 32'h110;
        dBus_cmd_valid        = 1'b1;
        dBus_cmd_payload_wr   = 1'b1;
        dBus_cmd_payload_addr = 32'h44;
        dBus_cmd_payload_data = 32'h12345678;
        dBus_cmd_payload_size = 4'h3;
        #1;
        chk("t3_full_iready", iBus_cmd_ready, 0);
        chk("t3_full_dready", dBus_cmd_ready, 1);
        chk("t3_full_we", m_cmd_we, 1);
        chk("t3_full_mask", m_cmd_mask, 4'h3);
        tick();
        dBus_cmd_valid = 1'b0;
        m_rsp_valid    = 1'b1;
        m_rsp_data     = 32'h77;
        #1;
        chk("t3_pop_iready", iBus_cmd_ready, 0);
        chk("t3_pop_mvalid", m_cmd_valid, 0);
        chk("t3_pop_irsp", iBus_rsp_ready, 1);
        tick();
        m_rsp_valid = 1'b0;
        #1;
        chk("t3_next_iready", iBus_cmd_ready, 1);
        chk("t3_next_addr", m_cmd_addr, 32'h110);
        tick();
        iBus_cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = 32'hA0 + 32'(k);
            #1;
            chk("t3_drain_irsp", iBus_rsp_ready, 1);
            chk("t3_drain_instr", iBus_rsp_instr, 32'hA0 + 32'(k));
            tick();
        end
        m_rsp_valid = 1'b0;

        // Test 4: interleaved reads I(0x0), D(0x100), I(0x4).
        iBus_cmd_valid      = 1'b1;
        iBus_cmd_payload_pc = 32'h0;
        #1;
        chk("t4_i0_iready", iBus_cmd_ready, 1);
        tick();
        iBus_cmd_valid        = 1'b0;
        dBus_cmd_valid        = 1'b1;
        dBus_cmd_payload_wr   = 1'b0;
        dBus_cmd_payload_addr = 32'h100;
        #1;
        chk("t4_d_dready", dBus_cmd_ready, 1);
        chk("t4_d_we", m_cmd_we, 0);
        tick();
        dBus_cmd_valid      = 1'b0;
        iBus_cmd_valid      = 1'b1;
        iBus_cmd_payload_pc = 32'h4;
        #1;
        chk("t4_i4_iready", iBus_cmd_ready, 1);
        tick();
        iBus_cmd_valid = 1'b0;
        m_rsp_valid    = 1'b1;
        m_rsp_data     = 32'h11;
        #1;
        chk("t4_r11_irsp", iBus_rsp_ready, 1);
        chk("t4_r11_drsp", dBus_rsp_valid, 0);
        chk("t4_r11_instr", iBus_rsp_instr, 32'h11);
        tick();
        m_rsp_data = 32'h22;
        #1;
        chk("t4_r22_drsp", dBus_rsp_valid, 1);
        chk("t4_r22_irsp", iBus_rsp_ready, 0);
        chk("t4_r22_data", dBus_rsp_data, 32'h22);
        tick();
        m_rsp_data = 32'h33;
        #1;
        chk("t4_r33_irsp", iBus_rsp_ready, 1);
        chk("t4_r33_instr", iBus_rsp_instr, 32'h33);
        tick();

        // Test 5: response with empty FIFO.
        m_rsp_data = 32'h99;
        #1;
        chk("t5_irsp", iBus_rsp_ready, 0);
        chk("t5_drsp", dBus_rsp_valid, 0);
        chk("t5_perr_before", protocol_err, 0);
        tick();
        m_rsp_valid = 1'b0;
        #1;
        chk("t5_perr_set", protocol_err, 1);
        tick();
        tick();
        #1;
        chk("t5_perr_sticky", protocol_err, 1);

        // Test 6: reset with two reads outstanding.
        iBus_cmd_valid        = 1'b1;
        dBus_cmd_valid        = 1'b1;
        dBus_cmd_payload_wr   = 1'b0;
        iBus_cmd_payload_pc   = 32'h200;
        dBus_cmd_payload_addr = 32'h300;
        #1;
        chk("t6_tie_dready", dBus_cmd_ready, 1);
        chk("t6_tie_iready", iBus_cmd_ready, 0);
        tick();
        dBus_cmd_valid = 1'b0;
        #1;
        chk("t6_i_iready", iBus_cmd_ready, 1);
        tick();
        rstf           = 1'b0;
        dBus_cmd_valid = 1'b1;
        #1;
        chk("t6_rst_iready", iBus_cmd_ready, 0);
        chk("t6_rst_dready", dBus_cmd_ready, 0);
        chk("t6_rst_mvalid", m_cmd_valid, 0);
        tick();
        #1;
        chk("t6_rst_perr", protocol_err, 0);
        rstf           = 1'b1;
        iBus_cmd_valid = 1'b0;
        dBus_cmd_valid = 1'b0;
        m_rsp_valid    = 1'b1;
        m_rsp_data     = 32'hEE;
        #1;
        chk("t6_stale_irsp", iBus_rsp_ready, 0);
        chk("t6_stale_drsp", dBus_rsp_valid, 0);
        tick();
        m_rsp_valid    = 1'b0;
        iBus_cmd_valid = 1'b1;
        dBus_cmd_valid = 1'b1;
        #1;
        chk("t6_first_tie_iready", iBus_cmd_ready, 1);
        chk("t6_first_tie_dready", dBus_cmd_ready, 0);
        chk("t6_stale_perr", protocol_err, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ibus_dbus_arbiter

// File: doc/ibus_dbus_arbiter.md
Name: ibus_dbus_arbiter

Overview:
- Shares one memory command/response port between the instruction fetch bus (iBus, read-only) and the data bus (dBus, read/write).
- Sits between the riscv core and a single-port instruction/data RAM, or a downstream data-bus demux.
- Round-robin arbitration, grant held until handshake, in-order read response routing via an internal tag FIFO.

Parameters:
- ADDR_W, 32, address width of all buses.
- DATA_W, 32, data width.
- MAX_OUT, 4, max outstanding reads (tag FIFO depth, power of 2, >=2).

Ports:
- clk  in  1  clock
- rstf  in  1  synchronous active-low reset
- iBus_cmd_valid  in  1  fetch request
- iBus_cmd_ready  out  1  fetch accepted
- iBus_cmd_payload_pc  in  ADDR_W  fetch address
- iBus_rsp_ready  out  1  fetch response valid (single-cycle pulse)
- iBus_rsp_instr  out  DATA_W  fetched instruction
- dBus_cmd_valid  in  1  data request
- dBus_cmd_ready  out  1  data accepted
- dBus_cmd_payload_addr  in  ADDR_W  data address
- dBus_cmd_payload_data  in  DATA_W  write data
- dBus_cmd_payload_size  in  4  byte-enable mask
- dBus_cmd_payload_wr  in  1  1=write, 0=read
- dBus_rsp_valid  out  1  read response valid
- dBus_rsp_data  out  DATA_W  read data
- m_cmd_valid  out  1  memory request
- m_cmd_ready  in  1  memory accepts
- m_cmd_we  out  1  write enable
- m_cmd_addr  out  ADDR_W  address
- m_cmd_data  out  DATA_W  write data
- m_cmd_mask  out  4  byte mask (4'h0 for iBus)
- m_rsp_valid  in  1  read data returned, in order, reads only
- m_rsp_data  in  DATA_W  read data
- protocol_err  out  1  sticky: response received with no outstanding read

Behaviour:
- Reset (rstf=0 at posedge): tag FIFO empty, last_grant=dBus (iBus wins the first tie), lock=0, protocol_err=0. All valid outputs 0 while rstf=0. Reset mid-transaction drops all outstanding tags; late m_rsp_valid is then counted as a protocol error.
- Eligibility:
  - iBus eligible = iBus_cmd_valid && !fifo_full.
  - dBus eligible = dBus_cmd_valid && (dBus_cmd_payload_wr || !fifo_full).
  - fifo_full uses the registered count; a same-cycle pop does not free a slot.
- Arbitration:
  - If lock=1, grant = locked owner.
  - Else if one requester is eligible, grant it.
  - If both are eligible, grant the one not equal to last_grant.
- Command path is combinational, zero latency: m_cmd_* = granted requester's fields; m_cmd_valid = granted eligible valid.
  - iBus: we=0, mask=0, data=0.
  - <req>_cmd_ready = granted && eligible && m_cmd_ready; the other requester's ready is 0.
- Lock: set when m_cmd_valid && !m_cmd_ready; cleared on handshake. The owner is stored in a register.
- last_grant updates only on handshake.
- Tag FIFO:
  - Push on a read handshake: tag 0=iBus, 1=dBus. Write handshakes push nothing.
  - Pop on m_rsp_valid.
  - Count width $clog2(MAX_OUT)+1; pointers wrap modulo MAX_OUT.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Response routing, combinational, zero latency:
  - iBus_rsp_ready = m_rsp_valid && !empty && head==0.
  - dBus_rsp_valid = m_rsp_valid && !empty && head==1.
  - Both rsp data outputs = m_rsp_data.
- m_rsp_valid while empty: no pop, no output pulse, protocol_err <= 1 until reset.
- Upstream responses are not backpressured; requesters must always accept.

Decomposition:
- Package arb_pkg: typedef req_id_e {REQ_IBUS=0, REQ_DBUS=1}; localparam MASK_NONE=4'h0.
- Sub-module tag_fifo: DEPTH=MAX_OUT, width 1, push/pop/full/empty/head. The arbiter top holds the grant, lock and muxes.

Test Plan:
- Both valid every cycle, reads, m_cmd_ready=1, memory returns after 1 cycle -> grants alternate I,D,I,D from reset; responses route to matching bus with correct data.
- dBus write (addr 0x40, data 0xDEADBEEF, mask 4'hF) while iBus idle, m_cmd_ready held 0 for 3 cycles -> m_cmd_* stable for all 3 cycles, lock held; iBus request arriving in cycle 2 is not granted until after the write handshake; no FIFO push.
- Issue 4 iBus reads with no responses -> 5th read stalls (iBus_cmd_ready=0); dBus write still granted; one response with a 5th read presented the same cycle -> read still stalled that cycle, accepted the next.
- Interleaved reads I(0x0),D(0x100),I(0x4) with responses 0x11,0x22,0x33 -> iBus gets 0x11 then 0x33; dBus gets 0x22; FIFO empty at end.
- m_rsp_valid pulse with FIFO empty -> no rsp pulse on either bus, protocol_err=1 and sticky until rstf=0.
- Assert rstf=0 with 2 reads outstanding -> next cycle cmd_ready=0 and FIFO empty; after release, first tie grants iBus; a stale response sets protocol_err.
